buffer_manager: RTL and testbench

BUFFER_MANAGER -- requirements
Module: buffer_manager

---
 rtl/gol_pkg.sv | 14 +
 rtl/buffer_manager_if.sv | 39 +++
 rtl/buffer_manager_bank_port_mux.sv | 71 +++++++
 rtl/buffer_manager.sv | 109 ++++++++++
 tb/tb_buffer_manager.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gol_pkg.sv
// Shared definitions for the frame-buffer manager.
//   BANK_CNT     : number of frame banks (double buffering)
//   bank_state_t : buffer manager FSM states
package gol_pkg;

    localparam int BANK_CNT = 2;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1,
        ST_SWAP  = 2'd2
    } bank_state_t;

endpackage

// File: rtl/buffer_manager_if.sv
// Data-path bundle of the buffer manager: logic-side read/write, render-side
// read, and the A/B ports of the two BRAM banks.
//   slave  : buffer_manager side (drives bank ports and read data)
//   master : user/BRAM side (drives addresses, write data, BRAM read data)
interface buffer_manager_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    import gol_pkg::*;

    logic [ADDR_W-1:0]                logic_rd_addr_in;
    logic [DATA_W-1:0]                logic_rd_data_out;
    logic                             logic_we_in;
    logic [ADDR_W-1:0]                logic_wr_addr_in;
    logic [DATA_W-1:0]                logic_wr_data_in;
    logic [ADDR_W-1:0]                render_addr_in;
    logic [DATA_W-1:0]                render_data_out;
    logic [BANK_CNT-1:0][ADDR_W-1:0]  bank_a_addr_out;
    logic [BANK_CNT-1:0]              bank_a_we_out;
    logic [BANK_CNT-1:0][DATA_W-1:0]  bank_a_wdata_out;
    logic [BANK_CNT-1:0][DATA_W-1:0]  bank_a_rdata_in;
    logic [BANK_CNT-1:0][ADDR_W-1:0]  bank_b_addr_out;
    logic [BANK_CNT-1:0][DATA_W-1:0]  bank_b_rdata_in;

    modport slave (
        input  logic_rd_addr_in, logic_we_in, logic_wr_addr_in, logic_wr_data_in,
               render_addr_in, bank_a_rdata_in, bank_b_rdata_in,
        output logic_rd_data_out, render_data_out, bank_a_addr_out, bank_a_we_out,
               bank_a_wdata_out, bank_b_addr_out
    );

    modport master (
        output logic_rd_addr_in, logic_we_in, logic_wr_addr_in, logic_wr_data_in,
               render_addr_in, bank_a_rdata_in, bank_b_rdata_in,
        input  logic_rd_data_out, render_data_out, bank_a_addr_out, bank_a_we_out,
               bank_a_wdata_out, bank_b_addr_out
    );

endinterface

// File: rtl/buffer_manager_bank_port_mux.sv
// bank_port_mux: combinational routing of the two BRAM banks.
//   front bank : port A = logic read, port B = render read
//   back bank  : port A = logic write (READY) or clear write (CLEAR), port B idle
//   read data  : selected by rd_sel_i (front select delayed to BRAM latency)
// Ports: front_sel_i, rd_sel_i, rst_ni, state_i, clr_addr_i, logic/render
// inputs, bank read data in; bank addr/we/wdata and read data out.
module bank_port_mux
    import gol_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int CLEAR_EN = 1
) (
    input  logic                             front_sel_i,
    input  logic                             rd_sel_i,
    input  logic                             rst_ni,
    input  bank_state_t                      state_i,
    input  logic [ADDR_W-1:0]                clr_addr_i,
    input  logic [ADDR_W-1:0]                logic_rd_addr_i,
    input  logic                             logic_we_i,
    input  logic [ADDR_W-1:0]                logic_wr_addr_i,
    input  logic [DATA_W-1:0]                logic_wr_data_i,
    input  logic [ADDR_W-1:0]                render_addr_i,
    input  logic [BANK_CNT-1:0][DATA_W-1:0]  bank_a_rdata_i,
    input  logic [BANK_CNT-1:0][DATA_W-1:0]  bank_b_rdata_i,
    output logic [BANK_CNT-1:0][ADDR_W-1:0]  bank_a_addr_o,
    output logic [BANK_CNT-1:0]              bank_a_we_o,
    output logic [BANK_CNT-1:0][DATA_W-1:0]  bank_a_wdata_o,
    output logic [BANK_CNT-1:0][ADDR_W-1:0]  bank_b_addr_o,
    output logic [DATA_W-1:0]                logic_rd_data_o,
    output logic [DATA_W-1:0]                render_data_o
);

    logic front;
    logic back;

    assign front = front_sel_i;
    assign back  = ~front_sel_i;

    always_comb begin
        bank_a_addr_o  = '0;
        bank_a_we_o    = '0;
        bank_a_wdata_o = '0;
        bank_b_addr_o  = '0;

        bank_a_addr_o[front] = logic_rd_addr_i;
        bank_b_addr_o[front] = render_addr_i;

        unique case (state_i)
            ST_READY: begin
                bank_a_addr_o[back]  = logic_wr_addr_i;
                bank_a_we_o[back]    = logic_we_i;
                bank_a_wdata_o[back] = logic_wr_data_i;
            end
            ST_CLEAR: begin
                bank_a_addr_o[back] = clr_addr_i;
                bank_a_we_o[back]   = (CLEAR_EN != 0);
            end
            default: ;
        endcase

        // Reset state is CLEAR; keep write enables quiet while reset is held.
        if (!rst_ni) begin
            bank_a_we_o = '0;
        end
    end

    assign logic_rd_data_o = bank_a_rdata_i[rd_sel_i];
    assign render_data_o   = bank_b_rdata_i[rd_sel_i];

endmodule

// File: rtl/buffer_manager.sv
// buffer_manager: double-buffered frame bank controller.
// A swap request in READY flips the front/back banks; the new back bank is
// then optionally zeroed one word per cycle before READY returns.
// Ports: clk_in, rst_in (async, active-low), buf_swap_in, buf_ready_out,
// front_sel_out, err_out (sticky swap-while-busy), bus (data-path bundle).
module buffer_manager
    import gol_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              buf_swap_in,
    output logic              buf_ready_out,
    output logic              front_sel_out,
    output logic              err_out,
    buffer_manager_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bank_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              front_sel_q, front_sel_d;
    logic              err_q, err_d;
    logic              rd_sel_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            front_sel_q <= 1'b0;
            err_q       <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            front_sel_q <= front_sel_d;
            err_q       <= err_d;
            rd_sel_q    <= front_sel_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        front_sel_d = front_sel_q;
        err_d       = err_q;

        unique case (state_q)
            ST_READY: begin
                if (buf_swap_in) begin
                    front_sel_d = ~front_sel_q;
                    state_d     = ST_SWAP;
                end
            end
            ST_SWAP: begin
                cnt_d   = '0;
                state_d = (CLEAR_EN != 0) ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                if ((CLEAR_EN == 0) || (cnt_q == LAST_ADDR)) begin
                    cnt_d   = '0;
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        if (buf_swap_in && (state_q != ST_READY)) begin
            err_d = 1'b1;
        end
    end

    assign buf_ready_out = (state_q == ST_READY);
    assign front_sel_out = front_sel_q;
    assign err_out       = err_q;

    bank_port_mux #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CLEAR_EN (CLEAR_EN)
    ) u_mux (
        .front_sel_i     (front_sel_q),
        .rd_sel_i        (rd_sel_q),
        .rst_ni          (rst_in),
        .state_i         (state_q),
        .clr_addr_i      (cnt_q),
        .logic_rd_addr_i (bus.logic_rd_addr_in),
        .logic_we_i      (bus.logic_we_in),
        .logic_wr_addr_i (bus.logic_wr_addr_in),
        .logic_wr_data_i (bus.logic_wr_data_in),
        .render_addr_i   (bus.render_addr_in),
        .bank_a_rdata_i  (bus.bank_a_rdata_in),
        .bank_b_rdata_i  (bus.bank_b_rdata_in),
        .bank_a_addr_o   (bus.bank_a_addr_out),
        .bank_a_we_o     (bus.bank_a_we_out),
        .bank_a_wdata_o  (bus.bank_a_wdata_out),
        .bank_b_addr_o   (bus.bank_b_addr_out),
        .logic_rd_data_o (bus.logic_rd_data_out),
        .render_data_o   (bus.render_data_out)
    );

endmodule

// File: tb/tb_buffer_manager.sv
// Self-checking bench for buffer_manager: one instance with clearing enabled
// (backed by a 1-cycle-latency BRAM model) and one with clearing disabled.
module tb_buffer_manager;
    import gol_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic swap1 = 1'b0;
    logic swap2 = 1'b0;
    logic ready1, front1, err1;
    logic ready2, front2, err2;

    always #5 clk = ~clk;

    buffer_manager_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    buffer_manager_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    buffer_manager #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_EN(1)) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .buf_swap_in   (swap1),
        .buf_ready_out (ready1),
        .front_sel_out (front1),
        .err_out       (err1),
        .bus           (bus1.slave)
    );

    buffer_manager #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CLEAR_EN(0)) dut2 (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .buf_swap_in   (swap2),
        .buf_ready_out (ready2),
        .front_sel_out (front2),
        .err_out       (err2),
        .bus           (bus2.slave)
    );

    assign bus2.logic_rd_addr_in = '0;
    assign bus2.logic_we_in      = 1'b0;
    assign bus2.logic_wr_addr_in = '0;
    assign bus2.logic_wr_data_in = '0;
    assign bus2.render_addr_in   = '0;
    assign bus2.bank_a_rdata_in  = '0;
    assign bus2.bank_b_rdata_in  = '0;

    // Dual-port BRAM model, read-first, 1-cycle read latency.
    logic [DW-1:0] mem [BANK_CNT][DEPTH];
    always @(posedge clk) begin
        for (int b = 0; b < BANK_CNT; b++) begin
            bus1.bank_a_rdata_in[b] <= mem[b][bus1.bank_a_addr_out[b]];
            bus1.bank_b_rdata_in[b] <= mem[b][bus1.bank_b_addr_out[b]];
            if (bus1.bank_a_we_out[b])
                mem[b][bus1.bank_a_addr_out[b]] <= bus1.bank_a_wdata_out[b];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference contents of each bank and expected front index.
    logic [DW-1:0] ref_mem [BANK_CNT][DEPTH];
    int            exp_front = 0;

    typedef struct {
        logic [DW-1:0] rnd;
        logic [DW-1:0] lgc;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          swap;
        logic          exp_ready;
        logic          exp_front;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ref(input int b);
        for (int a = 0; a < DEPTH; a++) ref_mem[b][a] = '0;
    endtask

    // Drive read addresses, queue the expected data, compare one cycle later.
    task automatic read_cycle(input int ra, input int la);
        exp_t e;
        bus1.render_addr_in   = AW'(ra);
        bus1.logic_rd_addr_in = AW'(la);
        sb.push_back('{rnd: ref_mem[exp_front][ra], lgc: ref_mem[exp_front][la]});
        tick();
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("render_data", bus1.render_data_out, e.rnd);
            check("logic_rd_data", bus1.logic_rd_data_out, e.lgc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int b = 0; b < BANK_CNT; b++)
            for (int a = 0; a < DEPTH; a++) begin
                mem[b][a]     = DW'(16'h5A00 + (b << 4) + a);
                ref_mem[b][a] = DW'(16'h5A00 + (b << 4) + a);
            end
        bus1.logic_rd_addr_in = '0;
        bus1.logic_we_in      = 1'b0;
        bus1.logic_wr_addr_in = '0;
        bus1.logic_wr_data_in = '0;
        bus1.render_addr_in   = '0;

        vecs[0] = '{1'b1, 4'd1,  16'h1111, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 4'd3,  16'hBEEF, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 4'd15, 16'hF00F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'd0,  16'hA5A5, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'd9,  16'h1234, 1'b1, 1'b0, 1'b1};

        repeat (3) tick();
        check("rst_ready", ready1, 0);
        check("rst_front", front1, 0);
        check("rst_err", err1, 0);
        check("rst_we", bus1.bank_a_we_out, 0);
        check("rst_ready2", ready2, 0);

        // Partial clear, then reset in the middle of it.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 7; k++) begin
            check("pclr_addr", bus1.bank_a_addr_out[1], k);
            tick();
        end
        check("pclr_addr7", bus1.bank_a_addr_out[1], 7);
        check("pclr_we7", bus1.bank_a_we_out, 2'b10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", bus1.bank_a_we_out, 0);
        check("mid_rst_ready", ready1, 0);
        check("mid_rst_front", front1, 0);
        repeat (2) tick();

        // Full clear of bank 1 after release.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            check("clr_we", bus1.bank_a_we_out, 2'b10);
            check("clr_addr", bus1.bank_a_addr_out[1], k);
            check("clr_wdata", bus1.bank_a_wdata_out[1], 0);
            check("clr_ready", ready1, 0);
            tick();
        end
        clear_ref(1);
        check("init_ready", ready1, 1);
        check("init_we", bus1.bank_a_we_out, 0);
        check("init_ready2", ready2, 1);

        // No-clear instance: ready low for exactly one cycle.
        swap2 = 1'b1;
        tick();
        swap2 = 1'b0;
        check("nc_ready_low", ready2, 0);
        check("nc_front", front2, 1);
        check("nc_we", bus2.bank_a_we_out, 0);
        tick();
        check("nc_ready_high", ready2, 1);
        check("nc_we2", bus2.bank_a_we_out, 0);
        check("nc_err", err2, 0);

        // Table: back-bank writes, last one coincident with a swap.
        for (int i = 0; i < 5; i++) begin
            bus1.logic_we_in      = vecs[i].we;
            bus1.logic_wr_addr_in = vecs[i].addr;
            bus1.logic_wr_data_in = vecs[i].data;
            swap1                 = vecs[i].swap;
            if (vecs[i].we) ref_mem[exp_front ^ 1][vecs[i].addr] = vecs[i].data;
            tick();
            if (vecs[i].swap) begin
                exp_front = exp_front ^ 1;
                clear_ref(exp_front ^ 1);
            end
            check("vec_ready", ready1, vecs[i].exp_ready);
            check("vec_front", front1, vecs[i].exp_front);
        end
        bus1.logic_we_in = 1'b0;
        swap1            = 1'b0;
        check("swap_we", bus1.bank_a_we_out, 0);

        // Reads from new front bank 1 while bank 0 is cleared.
        for (int t = 1; t <= DEPTH + 1; t++) begin
            read_cycle((t - 1) % DEPTH, 15 - ((t - 1) % DEPTH));
            if (t <= DEPTH) begin
                check("b0clr_we", bus1.bank_a_we_out, 2'b01);
                check("b0clr_addr", bus1.bank_a_addr_out[0], t - 1);
                check("b0clr_ready", ready1, 0);
            end else begin
                check("b0clr_done", ready1, 1);
                check("b0clr_we_off", bus1.bank_a_we_out, 0);
            end
        end

        // Swap back, then swaps while busy (SWAP and CLEAR).
        swap1 = 1'b1;
        tick();
        swap1 = 1'b0;
        exp_front = exp_front ^ 1;
        clear_ref(exp_front ^ 1);
        check("sw2_front", front1, 0);
        check("sw2_err", err1, 0);
        swap1 = 1'b1;
        tick();
        swap1 = 1'b0;
        check("busy_err", err1, 1);
        check("busy_front", front1, 0);
        for (int t = 1; t <= DEPTH; t++) begin
            if (t == 5) swap1 = 1'b1;
            tick();
            swap1 = 1'b0;
            check("busy_err_hold", err1, 1);
            check("busy_front_hold", front1, 0);
            if (t < DEPTH) begin
                check("b1clr_addr", bus1.bank_a_addr_out[1], t);
                check("b1clr_we", bus1.bank_a_we_out, 2'b10);
                check("b1clr_ready", ready1, 0);
            end else begin
                check("b1clr_done", ready1, 1);
            end
        end

        // Bank 0 was zeroed earlier and is now the front bank.
        for (int a = 0; a < DEPTH; a++) read_cycle(a, DEPTH - 1 - a);
        check("sb_empty", sb.size(), 0);

        repeat (3) tick();
        check("err_sticky", err1, 1);
        rst_n = 1'b0;
        #1;
        check("err_reset", err1, 0);
        check("final_ready", ready1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
